// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master controller.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ACK_A,
    WRITE,
    ACK_D,
    READ,
    MNACK,
    STOP
  } state_t;

  typedef logic [1:0] phase_t;

  localparam phase_t PH0 = 2'd0;
  localparam phase_t PH1 = 2'd1;
  localparam phase_t PH2 = 2'd2;
  localparam phase_t PH3 = 2'd3;

  function automatic logic [I2C_DATA_W-1:0] addr_byte(
    input logic [I2C_ADDR_W-1:0] addr,
    input logic                  rw
  );
    return {addr, rw};
  endfunction

endpackage

// File: rtl/i2c_scl_tick.sv
// SCL quarter-period divider: reports the current bit phase and a one-cycle
// tick on the last clk of each phase; i_hold freezes it for clock stretching.
module i2c_scl_tick
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_en,
  input  logic   i_hold,
  output logic   o_tick,
  output phase_t o_phase
);

  localparam int DIV_W = (CLK_DIV < 1) ? 1 : $clog2(CLK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_clk_div
      $error("i2c_scl_tick: CLK_DIV must be >= 1");
    end
  endgenerate

  logic [DIV_W-1:0] r_div;
  phase_t           r_phase;
  logic             w_tick;

  assign w_tick  = i_en && !i_hold && (r_div == DIV_LAST);
  assign o_tick  = w_tick;
  assign o_phase = r_phase;

  // Divider and phase counter, cleared whenever the sequencer is idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div   <= '0;
      r_phase <= PH0;
    end else if (!i_en) begin
      r_div   <= '0;
      r_phase <= PH0;
    end else if (i_hold) begin
      r_div   <= r_div;
      r_phase <= r_phase;
    end else if (w_tick) begin
      r_div   <= '0;
      r_phase <= r_phase + 2'd1;
    end else begin
      r_div   <= r_div + {{(DIV_W-1){1'b0}}, 1'b1};
      r_phase <= r_phase;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master sequencer (START, addr+R/W, ACK, data, ACK/NACK, STOP).
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL during the high phase.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  RESET_IN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [I2C_ADDR_W-1:0] cmd_addr,
  input  logic                  cmd_rw,
  input  logic [I2C_DATA_W-1:0] cmd_wdata,
  output logic                  done,
  output logic [I2C_DATA_W-1:0] rdata,
  output logic                  nack,
  output logic                  busy,
  output logic                  SCL_OE,
  output logic                  SDA_OE,
  input  logic                  SCL_IN,
  input  logic                  SDA_IN
);

  state_t                r_state;
  logic [2:0]            r_bit_cnt;
  logic [I2C_DATA_W-1:0] r_tx;
  logic [I2C_DATA_W-1:0] r_wdata;
  logic [I2C_DATA_W-1:0] r_rx;
  logic                  r_rw;
  logic                  r_scl_oe;
  logic                  r_sda_oe;
  logic                  r_done;
  logic [I2C_DATA_W-1:0] r_rdata;
  logic                  r_nack;
  logic                  r_busy;
  logic                  r_cmd_ready;

  logic                  w_run;
  logic                  w_tick;
  logic                  w_hold;
  phase_t                w_phase;

  assign w_run = (r_state != IDLE);

`ifdef I2C_CLK_STRETCH_EN
  assign w_hold = (w_phase == PH2) && !r_scl_oe && !SCL_IN;
`else
  logic w_unused_scl_in;
  assign w_unused_scl_in = SCL_IN;
  assign w_hold          = 1'b0;
`endif

  i2c_scl_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_scl_tick (
    .i_clk   (clk),
    .i_rst_n (RESET_IN),
    .i_en    (w_run),
    .i_hold  (w_hold),
    .o_tick  (w_tick),
    .o_phase (w_phase)
  );

  // Transaction sequencer; bus pins and status change only on phase ticks.
  always_ff @(posedge clk or negedge RESET_IN) begin
    if (!RESET_IN) begin
      r_state     <= IDLE;
      r_bit_cnt   <= 3'd0;
      r_tx        <= 8'h00;
      r_wdata     <= 8'h00;
      r_rx        <= 8'h00;
      r_rw        <= 1'b0;
      r_scl_oe    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_done      <= 1'b0;
      r_rdata     <= 8'h00;
      r_nack      <= 1'b0;
      r_busy      <= 1'b0;
      r_cmd_ready <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_tx        <= addr_byte(cmd_addr, cmd_rw);
            r_wdata     <= cmd_wdata;
            r_rw        <= cmd_rw;
            r_nack      <= 1'b0;
            r_rdata     <= 8'h00;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= START;
          end
        end
        default: begin
          if (w_tick && (w_phase == PH3)) begin
            // Bit boundary: SCL goes low and SDA takes the next bit's value.
            r_scl_oe <= 1'b1;
            case (r_state)
              START: begin
                r_state   <= ADDR;
                r_bit_cnt <= 3'd7;
                r_sda_oe  <= ~r_tx[7];
              end
              ADDR, WRITE: begin
                if (r_bit_cnt == 3'd0) begin
                  r_state  <= (r_state == ADDR) ? ACK_A : ACK_D;
                  r_sda_oe <= 1'b0;
                end else begin
                  r_bit_cnt <= r_bit_cnt - 3'd1;
                  r_tx      <= {r_tx[6:0], 1'b0};
                  r_sda_oe  <= ~r_tx[6];
                end
              end
              ACK_A: begin
                if (r_nack) begin
                  r_state  <= STOP;
                  r_sda_oe <= 1'b1;
                end else if (r_rw) begin
                  r_state   <= READ;
                  r_bit_cnt <= 3'd7;
                  r_sda_oe  <= 1'b0;
                end else begin
                  r_state   <= WRITE;
                  r_bit_cnt <= 3'd7;
                  r_tx      <= r_wdata;
                  r_sda_oe  <= ~r_wdata[7];
                end
              end
              ACK_D, MNACK: begin
                r_state  <= STOP;
                r_sda_oe <= 1'b1;
              end
              READ: begin
                if (r_bit_cnt == 3'd0) begin
                  r_state  <= MNACK;
                  r_rdata  <= r_rx;
                  r_sda_oe <= 1'b0;
                end else begin
                  r_bit_cnt <= r_bit_cnt - 3'd1;
                end
              end
              STOP: begin
                r_state     <= IDLE;
                r_scl_oe    <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_done      <= 1'b1;
                r_busy      <= 1'b0;
                r_cmd_ready <= 1'b1;
              end
              default: begin
                r_state     <= IDLE;
                r_scl_oe    <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_busy      <= 1'b0;
                r_cmd_ready <= 1'b1;
              end
            endcase
          end else if (w_tick) begin
            case (w_phase)
              PH1: begin
                // START drops SDA with SCL still high; every other bit raises SCL.
                if (r_state == START) begin
                  r_sda_oe <= 1'b1;
                end else begin
                  r_scl_oe <= 1'b0;
                end
              end
              PH2: begin
                if (r_state == START) begin
                  r_scl_oe <= 1'b1;
                end else if (r_state == STOP) begin
                  r_sda_oe <= 1'b0;
                end else begin
                  r_sda_oe <= r_sda_oe;
                end
                case (r_state)
                  ACK_A, ACK_D: r_nack <= r_nack | SDA_IN;
                  READ:         r_rx   <= {r_rx[6:0], SDA_IN};
                  default:      r_rx   <= r_rx;
                endcase
              end
              default: r_scl_oe <= r_scl_oe;
            endcase
          end else begin
            r_state <= r_state;
          end
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign rdata     = r_rdata;
  assign nack      = r_nack;
  assign SCL_OE    = r_scl_oe;
  assign SDA_OE    = r_sda_oe;

endmodule
